// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM states, default address
// and the bus levels that mean ACK / NACK.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_DATA,
    ST_RX_ACK,
    ST_TX_DATA,
    ST_TX_ACK_CHK
  } i2c_state_t;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h3A;
  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line, plus rise/fall
// detection against a one-cycle-delayed copy. Resets to 1 (idle bus level).
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target (slave) with 7-bit addressing, oversampled on pclk. Receives
// write bytes, returns tx_data on reads (0xFF on underrun), open-drain SDA.
module i2c_slave_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] data_slave_read,
  output logic       data_slave_read_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy,
  output logic       tx_underrun
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_load;
  logic [7:0] w_tx_byte;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .i_clk(pclk), .i_rst_n(preset), .i_async(scl_i),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .i_clk(pclk), .i_rst_n(preset), .i_async(sda_i),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  i2c_state_t r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift, r_tx_shift, r_data;
  logic       r_rw, r_mack, r_sda_oe, r_rx_pending;
  logic       r_valid, r_tx_ready, r_underrun, r_start, r_stop, r_busy;

  assign w_start   = w_sda_fall & w_scl;
  assign w_stop    = w_sda_rise & w_scl;
  assign w_tx_byte = tx_valid ? tx_data : 8'hFF;
  // Load the next transmit byte on the SCL fall that closes an ACK slot
  // (our address ACK on a read, or the master's ACK of the previous byte).
  assign w_load    = w_scl_fall &
                     (((r_state == ST_ADDR_ACK) && r_sda_oe && r_rw) ||
                      ((r_state == ST_TX_ACK_CHK) && r_mack));

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 8'h00;
      r_tx_shift   <= 8'h00;
      r_data       <= 8'h00;
      r_rw         <= 1'b0;
      r_mack       <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_rx_pending <= 1'b0;
      r_valid      <= 1'b0;
      r_tx_ready   <= 1'b0;
      r_underrun   <= 1'b0;
      r_start      <= 1'b0;
      r_stop       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid      <= r_rx_pending;
      r_rx_pending <= 1'b0;
      r_tx_ready   <= 1'b0;
      r_underrun   <= 1'b0;
      r_start      <= 1'b0;
      r_stop       <= 1'b0;
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
        r_mack   <= 1'b0;
        r_stop   <= 1'b1;
      end else if (w_start) begin
        r_state   <= ST_ADDR;
        r_bit_cnt <= 4'd0;
        r_mack    <= 1'b0;
        r_start   <= 1'b1;
      end else if (w_load) begin
        r_state    <= ST_TX_DATA;
        r_tx_shift <= {w_tx_byte[6:0], 1'b0};
        r_sda_oe   <= ~w_tx_byte[7];
        r_bit_cnt  <= 4'd0;
        r_mack     <= 1'b0;
        r_tx_ready <= tx_valid;
        r_underrun <= ~tx_valid;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_ADDR: if (w_scl_rise) begin
            r_shift   <= {r_shift[6:0], w_sda};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_rw <= w_sda;
              if (r_shift[6:0] == SLAVE_ADDR) begin
                r_state <= ST_ADDR_ACK;
                r_busy  <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          // First SCL fall starts driving ACK, second one ends the ACK slot.
          ST_ADDR_ACK, ST_RX_ACK: if (w_scl_fall) begin
            if (!r_sda_oe) begin
              r_sda_oe <= ~I2C_ACK;
            end else begin
              r_sda_oe  <= 1'b0;
              r_state   <= ST_RX_DATA;
              r_bit_cnt <= 4'd0;
            end
          end
          ST_RX_DATA: if (w_scl_rise) begin
            r_shift   <= {r_shift[6:0], w_sda};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_data       <= {r_shift[6:0], w_sda};
              r_rx_pending <= 1'b1;
              r_state      <= ST_RX_ACK;
            end
          end
          ST_TX_DATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_TX_ACK_CHK;
              end else begin
                r_sda_oe   <= ~r_tx_shift[7];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end
          end
          ST_TX_ACK_CHK: if (w_scl_rise) begin
            if (w_sda == I2C_NACK) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_mack <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign sda_oe                = r_sda_oe;
  assign data_slave_read       = r_data;
  assign data_slave_read_valid = r_valid;
  assign tx_ready              = r_tx_ready;
  assign tx_underrun           = r_underrun;
  assign start_det             = r_start;
  assign stop_det              = r_stop;
  assign busy                  = r_busy;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bit-banged I2C master driving i2c_slave_target; expected bytes and transmit
// events are queued by the stimulus and consumed by an independent monitor.
module tb_i2c_slave_target;

  logic       pclk = 1'b0;
  logic       preset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] data_slave_read;
  logic       data_slave_read_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, start_det, stop_det, busy, tx_underrun;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_target #(.SLAVE_ADDR(7'h3A), .SYNC_STAGES(2)) dut (
    .pclk(pclk), .preset(preset), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(sda_oe), .data_slave_read(data_slave_read),
    .data_slave_read_valid(data_slave_read_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .start_det(start_det), .stop_det(stop_det), .busy(busy),
    .tx_underrun(tx_underrun)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [6:0] MY_ADDR = 7'h3A;
  function automatic bit model_acks(input logic [6:0] a);
    return a == MY_ADDR;
  endfunction
  function automatic logic [7:0] model_tx(input bit v, input logic [7:0] d);
    return v ? d : 8'hFF;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_rx_q[$];
  bit         exp_tx_q[$];   // 1 = tx_ready expected, 0 = tx_underrun expected
  int start_cnt = 0, stop_cnt = 0, ready_cnt = 0, under_cnt = 0, quiet_viol = 0;
  bit watch_quiet = 1'b0;

  always @(negedge pclk) begin
    if (preset) begin
      if (data_slave_read_valid) begin
        if (exp_rx_q.size() == 0) check("rx_unexpected", {24'h0, data_slave_read}, 32'h100);
        else check("rx_byte", {24'h0, data_slave_read}, {24'h0, exp_rx_q.pop_front()});
      end
      if (tx_ready || tx_underrun) begin
        if (exp_tx_q.size() == 0) check("tx_unexpected", {30'h0, tx_ready, tx_underrun}, 32'h0);
        else begin
          bit e;
          e = exp_tx_q.pop_front();
          check("tx_event", {30'h0, tx_ready, tx_underrun}, {30'h0, e, ~e});
        end
      end
      if (start_det)   start_cnt++;
      if (stop_det)    stop_cnt++;
      if (tx_ready)    ready_cnt++;
      if (tx_underrun) under_cnt++;
      if (watch_quiet && (sda_oe || busy || data_slave_read_valid)) quiet_viol++;
    end
  end

  // ---------------- bus master ----------------
  task automatic wq();
    repeat (8) @(negedge pclk);
  endtask
  task automatic m_start();
    sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); sda_m = 1'b0; wq(); scl_m = 1'b0; wq();
  endtask
  task automatic m_stop();
    sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq(); wq();
  endtask
  task automatic m_wbit(input bit b);
    sda_m = b; wq(); scl_m = 1'b1; wq(); wq(); scl_m = 1'b0; wq();
  endtask
  task automatic m_rbit(output bit b);
    sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); b = sda_line; wq(); scl_m = 1'b0; wq();
  endtask
  task automatic m_wbyte(input logic [7:0] d, output bit acked);
    bit b;
    for (int i = 7; i >= 0; i--) m_wbit(d[i]);
    m_rbit(b);
    acked = ~b;
  endtask
  task automatic m_rbyte(output logic [7:0] d, input bit master_ack);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      m_rbit(b);
      d[i] = b;
    end
    m_wbit(~master_ack);
  endtask

  // ---------------- transactions ----------------
  logic [7:0] wbuf[4];

  task automatic do_write(input logic [6:0] addr, input int n);
    bit exp_ack, ack;
    int q0;
    exp_ack = model_acks(addr);
    q0 = quiet_viol;
    watch_quiet = ~exp_ack;
    if (exp_ack) for (int k = 0; k < n; k++) exp_rx_q.push_back(wbuf[k]);
    m_start();
    m_wbyte({addr, 1'b0}, ack);
    check("wr_addr_ack", {31'h0, ack}, {31'h0, exp_ack});
    for (int k = 0; k < n; k++) begin
      m_wbyte(wbuf[k], ack);
      check("wr_data_ack", {31'h0, ack}, {31'h0, exp_ack});
    end
    m_stop();
    watch_quiet = 1'b0;
    check("rx_drained", exp_rx_q.size(), 0);
    if (!exp_ack) check("wr_quiet", quiet_viol - q0, 0);
    $display("write addr=%02h bytes=%0d ack=%0d", addr, n, exp_ack);
  endtask

  task automatic do_read(input logic [6:0] addr, input int n, input bit v, input logic [7:0] d);
    bit exp_ack, ack;
    logic [7:0] got;
    int q0;
    exp_ack = model_acks(addr);
    tx_valid = v;
    tx_data  = d;
    q0 = quiet_viol;
    watch_quiet = ~exp_ack;
    if (exp_ack) for (int k = 0; k < n; k++) exp_tx_q.push_back(v);
    m_start();
    m_wbyte({addr, 1'b1}, ack);
    check("rd_addr_ack", {31'h0, ack}, {31'h0, exp_ack});
    if (exp_ack && ack) begin
      for (int k = 0; k < n; k++) begin
        m_rbyte(got, k < n - 1);
        check("rd_byte", {24'h0, got}, {24'h0, model_tx(v, d)});
      end
      check("rd_busy_after_nack", {31'h0, busy}, 32'h0);
    end
    m_stop();
    watch_quiet = 1'b0;
    if (!exp_ack) check("rd_quiet", quiet_viol - q0, 0);
    else exp_tx_q.delete();
    check("tx_drained", exp_tx_q.size(), 0);
    $display("read  addr=%02h bytes=%0d valid=%0d data=%02h", addr, n, v, d);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, u0;
    bit ack;
    logic [7:0] got, rd;

    // reset state
    repeat (4) @(negedge pclk);
    check("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
    check("rst_data", {24'h0, data_slave_read}, 32'h0);
    check("rst_pulses", {27'h0, data_slave_read_valid, tx_ready, tx_underrun, start_det, stop_det}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    preset = 1'b1;
    wq();

    // write 0x3A+W, 0xA5, 0x3C
    s0 = stop_cnt;
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    do_write(7'h3A, 2);
    check("wr_stop_count", stop_cnt - s0, 1);
    check("wr_last_byte", {24'h0, data_slave_read}, 32'h3C);

    // wrong address
    wbuf[0] = 8'h55;
    do_write(7'h3B, 1);

    // read with data available, master NACK
    r0 = ready_cnt;
    do_read(7'h3A, 1, 1'b1, 8'h5E);
    check("rd_ready_count", ready_cnt - r0, 1);

    // read underrun
    u0 = under_cnt;
    do_read(7'h3A, 1, 1'b0, 8'h12);
    check("rd_underrun_count", under_cnt - u0, 1);

    // write then repeated START into read
    s0 = start_cnt;
    rd = 8'($urandom);
    tx_valid = 1'b1; tx_data = rd;
    exp_rx_q.push_back(8'h11);
    exp_tx_q.push_back(1'b1);
    m_start();
    m_wbyte({7'h3A, 1'b0}, ack); check("rs_addr_w_ack", {31'h0, ack}, 32'h1);
    m_wbyte(8'h11, ack);         check("rs_data_ack", {31'h0, ack}, 32'h1);
    m_start();
    m_wbyte({7'h3A, 1'b1}, ack); check("rs_addr_r_ack", {31'h0, ack}, 32'h1);
    m_rbyte(got, 1'b0);          check("rs_rd_byte", {24'h0, got}, {24'h0, rd});
    m_stop();
    check("rs_start_count", start_cnt - s0, 2);
    check("rs_queues", exp_rx_q.size() + exp_tx_q.size(), 0);
    $display("repeated-start write 11 then read %02h", rd);

    // reset in the 4th data bit
    m_start();
    m_wbyte({7'h3A, 1'b0}, ack);
    check("rr_addr_ack", {31'h0, ack}, 32'h1);
    m_wbit(1'b1); m_wbit(1'b0); m_wbit(1'b1);
    sda_m = 1'b0; wq(); scl_m = 1'b1; wq();
    preset = 1'b0;
    repeat (2) @(negedge pclk);
    check("rr_sda_oe", {31'h0, sda_oe}, 32'h0);
    check("rr_data", {24'h0, data_slave_read}, 32'h0);
    check("rr_busy", {31'h0, busy}, 32'h0);
    check("rr_pulses", {27'h0, data_slave_read_valid, tx_ready, tx_underrun, start_det, stop_det}, 32'h0);
    scl_m = 1'b0; wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq();
    preset = 1'b1;
    wq(); wq();
    $display("reset applied mid-byte");
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    do_write(7'h3A, 2);
    check("rr_after_data", {24'h0, data_slave_read}, {24'h0, wbuf[1]});

    // randomized traffic
    for (int t = 0; t < 12; t++) begin
      int kind, n;
      logic [6:0] a;
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 1) == 0) ? 7'h3A : 7'($urandom);
      if (kind == 0) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
        do_write(7'h3A, n);
      end else if (kind == 1) begin
        n = $urandom_range(1, 2);
        for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
        do_write(a, n);
      end else begin
        do_read(a, $urandom_range(1, 2), 1'($urandom_range(0, 1)), 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_slave_target.md
I2C_SLAVE_TARGET -- requirements
Module: i2c_slave_target

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h3A, the 7-bit address it responds to.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth for scl_i/sda_i (minimum 2).
REQ-003 The block SHALL have port pclk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port preset, input, 1 bit, the reset; asynchronous, active-low.
REQ-005 The block SHALL have port scl_i, input, 1 bit, the bus SCL level (asynchronous).
REQ-006 The block SHALL have port sda_i, input, 1 bit, the bus SDA level (asynchronous).
REQ-007 The block SHALL have port sda_oe, output, 1 bit, which pulls SDA low when 1 (open-drain; never drives high).
REQ-008 The block SHALL have port data_slave_read, output, 8 bits, the last byte received from the master.
REQ-009 The block SHALL have port data_slave_read_valid, output, 1 bit, a 1-cycle pulse per received data byte.
REQ-010 The block SHALL have port tx_data, input, 8 bits, the byte to return on a master read.
REQ-011 The block SHALL have port tx_valid, input, 1 bit, which qualifies tx_data.
REQ-012 The block SHALL have port tx_ready, output, 1 bit, a 1-cycle pulse when tx_data is captured.
REQ-013 The block SHALL have ports start_det and stop_det, outputs, 1 bit each, 1-cycle pulses on START/repeated START and on STOP.
REQ-014 The block SHALL have ports busy and tx_underrun, outputs, 1 bit each: busy = addressed transfer in progress; tx_underrun = 1-cycle pulse when 0xFF is substituted.

Function
REQ-015 scl_i/sda_i SHALL pass through SYNC_STAGES flops; edges SHALL be detected from the synchronized value versus its one-cycle-delayed copy.
REQ-016 START SHALL be SDA falling while synchronized SCL is high; STOP SHALL be SDA rising while SCL is high; both SHALL be detected in every state.
REQ-017 FSM states SHALL be IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK_CHK.
REQ-018 START SHALL move the FSM to ADDR from any state and clear the bit counter; STOP SHALL move it to IDLE from any state and release sda_oe the same cycle.
REQ-019 SDA SHALL be sampled on SCL rising edges, MSB first; sda_oe SHALL change only on SCL falling edges, except on STOP or reset.
REQ-020 In ADDR, after 8 bits: on match with SLAVE_ADDR, assert sda_oe for the ACK bit (ADDR_ACK), then go to RX_DATA if R/W=0, or TX_DATA if R/W=1; on mismatch, leave sda_oe low and go to IDLE.
REQ-021 In RX_DATA, after the 8th SCL rising edge, data_slave_read SHALL update and data_slave_read_valid SHALL pulse one cycle later; data_slave_read SHALL hold until the next byte completes; the block SHALL ACK every byte (RX_ACK), then return to RX_DATA.
REQ-022 In TX_DATA, tx_data SHALL be captured on the SCL falling edge that ends the preceding ACK; tx_ready SHALL pulse that cycle if tx_valid=1, otherwise 0xFF is sent and tx_underrun pulses.
REQ-023 Transmit bits SHALL drive sda_oe = ~bit; in TX_ACK_CHK sda_oe SHALL be released; master ACK (SDA=0) leads to TX_DATA, NACK leads to IDLE.
REQ-024 busy SHALL be 1 from an address match until STOP, NACK, or a non-matching repeated-START address.
REQ-025 START and STOP detection SHALL take priority over a simultaneous SCL edge in the same cycle.

Reset
REQ-026 While preset=0, the FSM SHALL be IDLE, sda_oe=0, data_slave_read=8'h00, all pulse outputs 0, busy=0, and synchronizers SHALL be set to 1 (bus idle).
REQ-027 Reset mid-transfer SHALL release SDA immediately; after reset the block SHALL ignore the bus until the next START.

Structure
REQ-028 A shared package i2c_pkg SHALL hold the FSM state enum, the default address constant, and ACK/NACK level constants.
REQ-029 Sub-module i2c_sync_edge SHALL implement one synchronizer plus rise/fall detect; it SHALL be instantiated twice (SCL and SDA).

Verification
REQ-030 Write 0x3A+W, data 0xA5, 0x3C, then STOP -> ACK on all 3 bytes; data_slave_read_valid pulses twice with 0xA5 then 0x3C; stop_det pulses once.
REQ-031 Address 0x3B+W -> sda_oe stays 0 for the whole frame; no valid pulse; busy stays 0.
REQ-032 Read 0x3A+R, tx_valid=1, tx_data=0x5E, master NACK -> SDA carries 0x5E; tx_ready pulses once; FSM returns to IDLE.
REQ-033 Read with tx_valid=0 -> SDA carries 0xFF and tx_underrun pulses once.
REQ-034 Write 0x3A+W, 0x11, repeated START, 0x3A+R -> start_det pulses twice; the read phase is ACKed and TX_DATA is entered.
REQ-035 preset asserted during the 4th data bit -> sda_oe=0 within the reset, outputs at reset values, and the next full frame is received correctly.
